// File: rtl/ext_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// ext_mem_arb_pkg
// Shared types and helpers for the external-memory arbiter.
//   NB_REQUESTERS : number of requesters sharing the memory ports (2)
//   req_id_t      : requester index (1 bit)
//   rd_tag_t      : in-flight read tag {valid, id}
//   rr_grant()    : two-input round-robin grant decision
// -----------------------------------------------------------------------------
package ext_mem_arb_pkg;

    localparam int NB_REQUESTERS = 2;

    typedef logic [0:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, id: 1'b0};

    // One request is granted outright; on a conflict the requester that was
    // not granted last wins.
    function automatic logic [1:0] rr_grant(input logic [1:0] req, input req_id_t last);
        logic [1:0] gnt;
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == 1'b1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin arbiter. Grant is combinational from the requests and
// the "last granted" pointer; the pointer moves only on cycles that grant.
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous reset, active low (pointer resets to last = 1)
//   i_req  in  2  request vector, bit N = requester N
//   o_gnt  out 2  one-hot grant (or zero when nothing requests)
// -----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    import ext_mem_arb_pkg::*;

    req_id_t    r_last;
    logic [1:0] w_gnt;

    // Grant decision from current requests and pointer.
    always_comb begin
        w_gnt = rr_grant(i_req, r_last);
    end

    assign o_gnt = w_gnt;

    // Pointer register: remembers which requester was granted most recently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_gnt == 2'b01) begin
            r_last <= 1'b0;
        end else if (w_gnt == 2'b10) begin
            r_last <= 1'b1;
        end else begin
            r_last <= r_last;
        end
    end

endmodule

// File: rtl/ext_mem_arbiter.sv
// -----------------------------------------------------------------------------
// ext_mem_arbiter
// Shares one external-memory read port and one write port between requester 0
// (convolution controller) and requester 1 (host preload/readback). Read and
// write ports are arbitrated independently by two round-robin arbiters. Read
// data is steered back to its owner by a tag pipeline matched to the memory
// read latency.
// Optional feature macro: ARB_STALL_CNT_EN adds per-requester stall counters.
// Ports:
//   clk, arst_n_in                     clock, async active-low reset
//   rN_re / rN_raddr / rN_rgnt         read request, address, grant (N = 0, 1)
//   rN_rvalid / rN_rdata               read return valid and data
//   rN_we / rN_waddr / rN_wdata / rN_wgnt  write request, address, data, grant
//   rN_stall_cnt (ARB_STALL_CNT_EN)    saturating count of stalled cycles
//   mem_re / mem_read_addr / mem_qout  memory read port
//   mem_we / mem_write_addr / mem_din  memory write port
// -----------------------------------------------------------------------------
module ext_mem_arbiter #(
    parameter int LOG2_OF_MEM_HEIGHT = 20,
    parameter int DATA_WIDTH         = 32,
    parameter int READ_LATENCY       = 1   // legal range 1..4
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          r0_re,
    input  logic [LOG2_OF_MEM_HEIGHT-1:0] r0_raddr,
    output logic                          r0_rgnt,
    output logic                          r0_rvalid,
    output logic [DATA_WIDTH-1:0]         r0_rdata,
    input  logic                          r0_we,
    input  logic [LOG2_OF_MEM_HEIGHT-1:0] r0_waddr,
    input  logic [DATA_WIDTH-1:0]         r0_wdata,
    output logic                          r0_wgnt,
    input  logic                          r1_re,
    input  logic [LOG2_OF_MEM_HEIGHT-1:0] r1_raddr,
    output logic                          r1_rgnt,
    output logic                          r1_rvalid,
    output logic [DATA_WIDTH-1:0]         r1_rdata,
    input  logic                          r1_we,
    input  logic [LOG2_OF_MEM_HEIGHT-1:0] r1_waddr,
    input  logic [DATA_WIDTH-1:0]         r1_wdata,
    output logic                          r1_wgnt,
`ifdef ARB_STALL_CNT_EN
    output logic [31:0]                   r0_stall_cnt,
    output logic [31:0]                   r1_stall_cnt,
`endif
    output logic                          mem_re,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
    input  logic [DATA_WIDTH-1:0]         mem_qout,
    output logic                          mem_we,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0]         mem_din
);
    import ext_mem_arb_pkg::*;

    localparam int TAG_DEPTH = READ_LATENCY + 1;

    logic [1:0]                    w_rd_gnt;
    logic [1:0]                    w_wr_gnt;
    logic                          w_rd_accept;
    logic                          w_wr_accept;
    req_id_t                       w_rd_winner;
    req_id_t                       w_wr_winner;
    logic [LOG2_OF_MEM_HEIGHT-1:0] w_rd_addr;
    logic [LOG2_OF_MEM_HEIGHT-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0]         w_wr_data;

    logic                          r_mem_re;
    logic [LOG2_OF_MEM_HEIGHT-1:0] r_mem_read_addr;
    logic                          r_mem_we;
    logic [LOG2_OF_MEM_HEIGHT-1:0] r_mem_write_addr;
    logic [DATA_WIDTH-1:0]         r_mem_din;
    rd_tag_t                       r_tags [TAG_DEPTH];

    rr_arbiter2 u_rd_arb (
        .clk   (clk),
        .rst_n (arst_n_in),
        .i_req ({r1_re, r0_re}),
        .o_gnt (w_rd_gnt)
    );

    rr_arbiter2 u_wr_arb (
        .clk   (clk),
        .rst_n (arst_n_in),
        .i_req ({r1_we, r0_we}),
        .o_gnt (w_wr_gnt)
    );

    assign r0_rgnt = w_rd_gnt[0];
    assign r1_rgnt = w_rd_gnt[1];
    assign r0_wgnt = w_wr_gnt[0];
    assign r1_wgnt = w_wr_gnt[1];

    // Grants are only issued to active requests, so any grant bit is an accept.
    assign w_rd_accept = |w_rd_gnt;
    assign w_wr_accept = |w_wr_gnt;
    assign w_rd_winner = w_rd_gnt[1];
    assign w_wr_winner = w_wr_gnt[1];

    // Select the winning requester's address and data.
    always_comb begin
        w_rd_addr = r0_raddr;
        w_wr_addr = r0_waddr;
        w_wr_data = r0_wdata;
        if (w_rd_winner == 1'b1) begin
            w_rd_addr = r1_raddr;
        end else begin
            w_rd_addr = r0_raddr;
        end
        if (w_wr_winner == 1'b1) begin
            w_wr_addr = r1_waddr;
            w_wr_data = r1_wdata;
        end else begin
            w_wr_addr = r0_waddr;
            w_wr_data = r0_wdata;
        end
    end

    // Memory read port registers; address holds when nothing is accepted.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_mem_re        <= 1'b0;
            r_mem_read_addr <= '0;
        end else begin
            r_mem_re <= w_rd_accept;
            if (w_rd_accept) begin
                r_mem_read_addr <= w_rd_addr;
            end else begin
                r_mem_read_addr <= r_mem_read_addr;
            end
        end
    end

    // Memory write port registers; address and data hold when idle.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_mem_we         <= 1'b0;
            r_mem_write_addr <= '0;
            r_mem_din        <= '0;
        end else begin
            r_mem_we <= w_wr_accept;
            if (w_wr_accept) begin
                r_mem_write_addr <= w_wr_addr;
                r_mem_din        <= w_wr_data;
            end else begin
                r_mem_write_addr <= r_mem_write_addr;
                r_mem_din        <= r_mem_din;
            end
        end
    end

    // Tag pipeline: one entry per cycle between accept and data return, so
    // the last entry lines up with mem_qout for the matching read.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                r_tags[i] <= RD_TAG_IDLE;
            end
        end else begin
            r_tags[0] <= '{valid: w_rd_accept, id: w_rd_winner};
            for (int i = 1; i < TAG_DEPTH; i++) begin
                r_tags[i] <= r_tags[i-1];
            end
        end
    end

    assign r0_rvalid = r_tags[TAG_DEPTH-1].valid && (r_tags[TAG_DEPTH-1].id == 1'b0);
    assign r1_rvalid = r_tags[TAG_DEPTH-1].valid && (r_tags[TAG_DEPTH-1].id == 1'b1);
    assign r0_rdata  = mem_qout;
    assign r1_rdata  = mem_qout;

    assign mem_re         = r_mem_re;
    assign mem_read_addr  = r_mem_read_addr;
    assign mem_we         = r_mem_we;
    assign mem_write_addr = r_mem_write_addr;
    assign mem_din        = r_mem_din;

`ifdef ARB_STALL_CNT_EN
    logic        w_stall0;
    logic        w_stall1;
    logic [31:0] r_stall_cnt0;
    logic [31:0] r_stall_cnt1;

    assign w_stall0 = (r0_re && !w_rd_gnt[0]) || (r0_we && !w_wr_gnt[0]);
    assign w_stall1 = (r1_re && !w_rd_gnt[1]) || (r1_we && !w_wr_gnt[1]);

    // Saturating stall counters, one per requester.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_stall_cnt0 <= 32'd0;
            r_stall_cnt1 <= 32'd0;
        end else begin
            if (w_stall0 && (r_stall_cnt0 != 32'hFFFF_FFFF)) begin
                r_stall_cnt0 <= r_stall_cnt0 + 32'd1;
            end else begin
                r_stall_cnt0 <= r_stall_cnt0;
            end
            if (w_stall1 && (r_stall_cnt1 != 32'hFFFF_FFFF)) begin
                r_stall_cnt1 <= r_stall_cnt1 + 32'd1;
            end else begin
                r_stall_cnt1 <= r_stall_cnt1;
            end
        end
    end

    assign r0_stall_cnt = r_stall_cnt0;
    assign r1_stall_cnt = r_stall_cnt1;
`endif

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ext_mem_arbiter
// Directed bench for ext_mem_arbiter: one instance at READ_LATENCY=1 with a
// one-cycle memory model, one at READ_LATENCY=3 with a three-stage memory.
// -----------------------------------------------------------------------------
module tb_ext_mem_arbiter;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          arst_n_in;
    int            total = 0;
    int            bad   = 0;

    // instance with READ_LATENCY = 1
    logic          r0_re, r1_re, r0_we, r1_we;
    logic [AW-1:0] r0_raddr, r1_raddr, r0_waddr, r1_waddr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_rgnt, r1_rgnt, r0_wgnt, r1_wgnt, r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          mem_re, mem_we;
    logic [AW-1:0] mem_read_addr, mem_write_addr;
    logic [DW-1:0] mem_qout, mem_din;
    logic [DW-1:0] mem1 [256];

    // instance with READ_LATENCY = 3
    logic          b_r1_re;
    logic [AW-1:0] b_r1_raddr;
    logic          b_r0_rgnt, b_r1_rgnt, b_r0_wgnt, b_r1_wgnt, b_r0_rvalid, b_r1_rvalid;
    logic [DW-1:0] b_r0_rdata, b_r1_rdata;
    logic          b_mem_re, b_mem_we;
    logic [AW-1:0] b_mem_read_addr, b_mem_write_addr;
    logic [DW-1:0] b_mem_qout, b_mem_din, b_s0, b_s1;

`ifdef ARB_STALL_CNT_EN
    logic [31:0]   r0_stall_cnt, r1_stall_cnt, b_r0_stall_cnt, b_r1_stall_cnt;
`endif

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        if (a == 20'h00010) return 32'h0000_CAFE;
        return 32'h5A00_0000 | {12'h000, a};
    endfunction

    ext_mem_arbiter #(.LOG2_OF_MEM_HEIGHT(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut (
        .clk(clk), .arst_n_in(arst_n_in),
        .r0_re(r0_re), .r0_raddr(r0_raddr), .r0_rgnt(r0_rgnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r0_we(r0_we), .r0_waddr(r0_waddr), .r0_wdata(r0_wdata), .r0_wgnt(r0_wgnt),
        .r1_re(r1_re), .r1_raddr(r1_raddr), .r1_rgnt(r1_rgnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .r1_we(r1_we), .r1_waddr(r1_waddr), .r1_wdata(r1_wdata), .r1_wgnt(r1_wgnt),
`ifdef ARB_STALL_CNT_EN
        .r0_stall_cnt(r0_stall_cnt), .r1_stall_cnt(r1_stall_cnt),
`endif
        .mem_re(mem_re), .mem_read_addr(mem_read_addr), .mem_qout(mem_qout),
        .mem_we(mem_we), .mem_write_addr(mem_write_addr), .mem_din(mem_din)
    );

    ext_mem_arbiter #(.LOG2_OF_MEM_HEIGHT(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) dut3 (
        .clk(clk), .arst_n_in(arst_n_in),
        .r0_re(1'b0), .r0_raddr(20'h0), .r0_rgnt(b_r0_rgnt), .r0_rvalid(b_r0_rvalid), .r0_rdata(b_r0_rdata),
        .r0_we(1'b0), .r0_waddr(20'h0), .r0_wdata(32'h0), .r0_wgnt(b_r0_wgnt),
        .r1_re(b_r1_re), .r1_raddr(b_r1_raddr), .r1_rgnt(b_r1_rgnt), .r1_rvalid(b_r1_rvalid), .r1_rdata(b_r1_rdata),
        .r1_we(1'b0), .r1_waddr(20'h0), .r1_wdata(32'h0), .r1_wgnt(b_r1_wgnt),
`ifdef ARB_STALL_CNT_EN
        .r0_stall_cnt(b_r0_stall_cnt), .r1_stall_cnt(b_r1_stall_cnt),
`endif
        .mem_re(b_mem_re), .mem_read_addr(b_mem_read_addr), .mem_qout(b_mem_qout),
        .mem_we(b_mem_we), .mem_write_addr(b_mem_write_addr), .mem_din(b_mem_din)
    );

    // one-cycle synchronous memory
    always @(posedge clk) begin
        if (mem_we) mem1[mem_write_addr[7:0]] <= mem_din;
        if (mem_re) mem_qout <= mem1[mem_read_addr[7:0]];
    end

    // three-cycle read memory (contents given by memval)
    always @(posedge clk) begin
        if (b_mem_re) b_s0 <= memval(b_mem_read_addr);
        b_s1       <= b_s0;
        b_mem_qout <= b_s1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        r0_re = 1'b0; r1_re = 1'b0; r0_we = 1'b0; r1_we = 1'b0;
        r0_raddr = '0; r1_raddr = '0; r0_waddr = '0; r1_waddr = '0;
        r0_wdata = '0; r1_wdata = '0;
        b_r1_re = 1'b0; b_r1_raddr = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        arst_n_in = 1'b0;
        tick();
        arst_n_in = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        arst_n_in = 1'b0;
        #2;
        total++;
        if ({r0_rgnt, r1_rgnt, r0_wgnt, r1_wgnt, r0_rvalid, r1_rvalid, mem_re, mem_we} !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {r0_rgnt, r1_rgnt, r0_wgnt, r1_wgnt, r0_rvalid, r1_rvalid, mem_re, mem_we});
        end
        total++;
        if ({mem_read_addr, mem_write_addr, mem_din} !== 72'h0) begin
            bad++;
            $display("FAIL reset_data: raddr=%h waddr=%h din=%h want 0", mem_read_addr, mem_write_addr, mem_din);
        end
        tick();
        arst_n_in = 1'b1;
        tick();
    endtask

    task automatic test_solo_read;
        r0_re = 1'b1; r0_raddr = 20'h00010;
        #1;
        total++;
        if ({r0_rgnt, r1_rgnt} !== 2'b10) begin
            bad++; $display("FAIL solo_gnt: got r0/r1=%b want 10", {r0_rgnt, r1_rgnt});
        end
        tick();
        r0_re = 1'b0;
        total++;
        if (mem_re !== 1'b1 || mem_read_addr !== 20'h00010 || r0_rvalid !== 1'b0) begin
            bad++; $display("FAIL solo_mem_re: re=%b addr=%h rvalid=%b want 1 00010 0", mem_re, mem_read_addr, r0_rvalid);
        end
        tick();
        total++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== 32'h0000_CAFE || r1_rvalid !== 1'b0) begin
            bad++; $display("FAIL solo_rvalid: v0=%b d=%h v1=%b want 1 0000cafe 0", r0_rvalid, r0_rdata, r1_rvalid);
        end
        tick();
        total++;
        if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0 || mem_re !== 1'b0) begin
            bad++; $display("FAIL solo_after: v0=%b v1=%b re=%b want 0 0 0", r0_rvalid, r1_rvalid, mem_re);
        end
    endtask

    task automatic test_conflict;
        logic exp_g0, exp_v0, exp_v1;
        do_reset();
        r0_re = 1'b1; r0_raddr = 20'h00020;
        r1_re = 1'b1; r1_raddr = 20'h00021;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin r0_re = 1'b0; r1_re = 1'b0; end
            #1;
            if (i < 4) begin
                exp_g0 = ((i % 2) == 0);
                total++;
                if (r0_rgnt !== exp_g0 || r1_rgnt !== !exp_g0) begin
                    bad++; $display("FAIL conflict_gnt[%0d]: got r0/r1=%b%b want %b%b", i, r0_rgnt, r1_rgnt, exp_g0, !exp_g0);
                end
            end
            exp_v0 = (i >= 2) && (((i - 2) % 2) == 0);
            exp_v1 = (i >= 2) && (((i - 2) % 2) == 1);
            total++;
            if (r0_rvalid !== exp_v0 || r1_rvalid !== exp_v1) begin
                bad++; $display("FAIL conflict_rvalid[%0d]: got %b%b want %b%b", i, r0_rvalid, r1_rvalid, exp_v0, exp_v1);
            end
            if (exp_v0 || exp_v1) begin
                total++;
                if (mem_qout !== memval(exp_v0 ? 20'h00020 : 20'h00021) ||
                    (exp_v0 && r0_rdata !== memval(20'h00020)) || (exp_v1 && r1_rdata !== memval(20'h00021))) begin
                    bad++; $display("FAIL conflict_data[%0d]: got r0=%h r1=%h", i, r0_rdata, r1_rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_concurrent;
        r0_we = 1'b1; r0_waddr = 20'h00003; r0_wdata = 32'h0000_0005;
        r1_re = 1'b1; r1_raddr = 20'h00007;
        #1;
        total++;
        if ({r0_wgnt, r1_wgnt, r0_rgnt, r1_rgnt} !== 4'b1001) begin
            bad++; $display("FAIL conc_gnt: got wg0 wg1 rg0 rg1=%b want 1001", {r0_wgnt, r1_wgnt, r0_rgnt, r1_rgnt});
        end
        tick();
        idle_inputs();
        total++;
        if (mem_we !== 1'b1 || mem_write_addr !== 20'h00003 || mem_din !== 32'h5 ||
            mem_re !== 1'b1 || mem_read_addr !== 20'h00007) begin
            bad++; $display("FAIL conc_mem: we=%b wa=%h din=%h re=%b ra=%h want 1 00003 5 1 00007",
                            mem_we, mem_write_addr, mem_din, mem_re, mem_read_addr);
        end
        tick();
        total++;
        if (r1_rvalid !== 1'b1 || r1_rdata !== memval(20'h00007) || r0_rvalid !== 1'b0 || mem_we !== 1'b0) begin
            bad++; $display("FAIL conc_return: v1=%b d=%h v0=%b we=%b want 1 %h 0 0", r1_rvalid, r1_rdata, r0_rvalid, mem_we, memval(20'h00007));
        end
        total++;
        if (mem_write_addr !== 20'h00003 || mem_din !== 32'h5 || mem_read_addr !== 20'h00007) begin
            bad++; $display("FAIL conc_hold: wa=%h din=%h ra=%h want 00003 5 00007", mem_write_addr, mem_din, mem_read_addr);
        end
        tick();
    endtask

    task automatic test_reset_midflight;
        r0_re = 1'b1; r0_raddr = 20'h00010;
        #1;
        total++;
        if (r0_rgnt !== 1'b1) begin
            bad++; $display("FAIL mid_accept: got r0_rgnt=%b want 1", r0_rgnt);
        end
        tick();
        r0_re = 1'b0;
        arst_n_in = 1'b0;
        #1;
        total++;
        if (mem_re !== 1'b0 || mem_read_addr !== 20'h0) begin
            bad++; $display("FAIL mid_clear: re=%b ra=%h want 0 00000", mem_re, mem_read_addr);
        end
        tick();
        arst_n_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin
                bad++; $display("FAIL mid_no_rvalid[%0d]: got %b%b want 00", i, r0_rvalid, r1_rvalid);
            end
            tick();
        end
        // pointers back at reset: requester 0 wins a conflict on both ports
        r0_re = 1'b1; r1_re = 1'b1; r0_we = 1'b1; r1_we = 1'b1;
        #1;
        total++;
        if ({r0_rgnt, r1_rgnt, r0_wgnt, r1_wgnt} !== 4'b1010) begin
            bad++; $display("FAIL mid_pointer: got rg0 rg1 wg0 wg1=%b want 1010", {r0_rgnt, r1_rgnt, r0_wgnt, r1_wgnt});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back_lat3;
        logic exp_v;
        do_reset();
        b_r1_re = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 5) b_r1_raddr = 20'(i);
            if (i == 5) b_r1_re = 1'b0;
            #1;
            if (i < 5) begin
                total++;
                if (b_r1_rgnt !== 1'b1) begin
                    bad++; $display("FAIL lat3_gnt[%0d]: got %b want 1", i, b_r1_rgnt);
                end
            end
            exp_v = (i >= 4) && (i <= 8);
            total++;
            if (b_r1_rvalid !== exp_v || b_r0_rvalid !== 1'b0) begin
                bad++; $display("FAIL lat3_rvalid[%0d]: got r1=%b r0=%b want %b 0", i, b_r1_rvalid, b_r0_rvalid, exp_v);
            end
            if (exp_v) begin
                total++;
                if (b_r1_rdata !== memval(20'(i - 4))) begin
                    bad++; $display("FAIL lat3_data[%0d]: got %h want %h", i, b_r1_rdata, memval(20'(i - 4)));
                end
            end
            tick();
        end
    endtask

`ifdef ARB_STALL_CNT_EN
    task automatic test_stall_cnt;
        do_reset();
        r0_re = 1'b1; r1_re = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        idle_inputs();
        total++;
        if (r0_stall_cnt !== 32'd5 || r1_stall_cnt !== 32'd5) begin
            bad++; $display("FAIL stall_cnt: got %0d %0d want 5 5", r0_stall_cnt, r1_stall_cnt);
        end
        arst_n_in = 1'b0;
        #1;
        total++;
        if (r0_stall_cnt !== 32'd0 || r1_stall_cnt !== 32'd0) begin
            bad++; $display("FAIL stall_reset: got %0d %0d want 0 0", r0_stall_cnt, r1_stall_cnt);
        end
        tick();
        arst_n_in = 1'b1;
        tick();
    endtask
`endif

    initial begin
        for (int a = 0; a < 256; a++) mem1[a] = memval(20'(a));
        mem_qout = '0; b_s0 = '0; b_s1 = '0; b_mem_qout = '0;
        arst_n_in = 1'b1;
        idle_inputs();
        #3;
        test_reset();
        test_solo_read();
        test_conflict();
        test_concurrent();
        test_reset_midflight();
        test_back_to_back_lat3();
`ifdef ARB_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
